ps2_mouse_rx: RTL

PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

---
 rtl/ps2_mouse_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: frame capture, packet assembly, motion decode and a
// saturating cursor position accumulator.
module ps2_mouse_rx #(
    parameter int unsigned WHEEL       = 0,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned POS_W       = 11,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MAX       = 479
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [9:0]       dx,
    output logic [9:0]       dy,
    output logic [3:0]       dz,
    output logic [2:0]       buttons,
    output logic             x_ovf,
    output logic             y_ovf,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             new_data,
    output logic             err
);

    localparam int unsigned PW = POS_W + 2;
    localparam int unsigned IW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);
    localparam logic [1:0] LAST = (WHEEL != 0) ? 2'd3 : 2'd2;
    localparam logic signed [PW-1:0] XMAX_S = PW'(X_MAX);
    localparam logic signed [PW-1:0] YMAX_S = PW'(Y_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [1:0]    r_idx;
    logic [IW-1:0] r_idle;
    // header byte without its always-one bit 3: {yovf, xovf, ysign, xsign, btn[2:0]}
    logic [6:0]    r_hdr;
    logic [7:0]    r_b1;
    logic [7:0]    r_b2;
    logic          r_ck_s1, r_ck_s2, r_ck_d;
    logic          r_dt_s1, r_dt_s2;

    logic                 w_fall;
    logic [7:0]           w_b2;
    logic signed [9:0]    w_dx;
    logic signed [9:0]    w_dy;
    logic [3:0]           w_dz;
    logic signed [PW-1:0] w_sum_x;
    logic signed [PW-1:0] w_sum_y;

    // clamp a widened position sum into [0, hi]
    function automatic logic [POS_W-1:0] clamp(input logic signed [PW-1:0] v,
                                               input logic signed [PW-1:0] hi);
        if (v[PW-1])
            return '0;
        else if (v > hi)
            return POS_W'(hi);
        else
            return POS_W'(v);
    endfunction

    assign w_fall  = r_ck_d & ~r_ck_s2;
    // on the last byte the final data byte is still in the shifter
    assign w_b2    = (WHEEL != 0) ? r_b2 : r_shift;
    assign w_dx    = {r_hdr[3], r_hdr[3], r_b1};
    assign w_dy    = -$signed({r_hdr[4], r_hdr[4], w_b2});
    assign w_dz    = (WHEEL != 0) ? r_shift[3:0] : 4'd0;
    assign w_sum_x = $signed({2'b00, pos_x}) + PW'(w_dx);
    assign w_sum_y = $signed({2'b00, pos_y}) + PW'(w_dy);

    // two-flop synchronisers plus a delayed copy of ps2_clk for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ck_s1 <= 1'b1;
            r_ck_s2 <= 1'b1;
            r_ck_d  <= 1'b1;
            r_dt_s1 <= 1'b1;
            r_dt_s2 <= 1'b1;
        end else begin
            r_ck_s1 <= ps2_clk;
            r_ck_s2 <= r_ck_s1;
            r_ck_d  <= r_ck_s2;
            r_dt_s1 <= ps2_data;
            r_dt_s2 <= r_dt_s1;
        end
    end

    // frame FSM, packet assembly, idle timeout and registered decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par_ok <= 1'b0;
            r_idx    <= '0;
            r_idle   <= '0;
            r_hdr    <= '0;
            r_b1     <= '0;
            r_b2     <= '0;
            dx       <= '0;
            dy       <= '0;
            dz       <= '0;
            buttons  <= '0;
            x_ovf    <= 1'b0;
            y_ovf    <= 1'b0;
            pos_x    <= POS_W'(X_MAX / 2);
            pos_y    <= POS_W'(Y_MAX / 2);
            new_data <= 1'b0;
            err      <= 1'b0;
        end else begin
            new_data <= 1'b0;
            err      <= 1'b0;
            if (w_fall) begin
                r_idle <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dt_s2) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {r_dt_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_par_ok <= ^{r_shift, r_dt_s2};
                        r_state  <= ST_STOP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        if (!r_par_ok || !r_dt_s2) begin
                            err   <= 1'b1;
                            r_idx <= '0;
                        end else if (r_idx == 2'd0 && !r_shift[3]) begin
                            err <= 1'b1;
                        end else if (r_idx == LAST) begin
                            r_idx    <= '0;
                            new_data <= 1'b1;
                            dx       <= w_dx;
                            dy       <= w_dy;
                            dz       <= w_dz;
                            buttons  <= r_hdr[2:0];
                            x_ovf    <= r_hdr[5];
                            y_ovf    <= r_hdr[6];
                            if (!r_hdr[5] && !r_hdr[6]) begin
                                pos_x <= clamp(w_sum_x, XMAX_S);
                                pos_y <= clamp(w_sum_y, YMAX_S);
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                            case (r_idx)
                                2'd0:    r_hdr <= {r_shift[7:4], r_shift[2:0]};
                                2'd1:    r_b1  <= r_shift;
                                default: r_b2  <= r_shift;
                            endcase
                        end
                    end
                endcase
            end else if (r_idle == IDLE_MAX) begin
                if (r_state != ST_IDLE || r_idx != 2'd0) begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    err     <= 1'b1;
                end
            end else begin
                r_idle <= r_idle + IW'(1);
            end
        end
    end

endmodule
